// File: rtl/axi_master_port.sv
// Single-outstanding AXI4 initiator: request/stream front end to AW/W/B and AR/R.
// INCR bursts of full-width beats, one burst in flight at a time.
module axi_master_port #(
   parameter int ID_BITS    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_BITS   = 8,
   parameter int SIZE_BITS  = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ID_BITS-1:0]      req_id,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [LEN_BITS-1:0]     req_len,
   input  logic [DATA_WIDTH-1:0]   wd_data,
   input  logic                    wd_valid,
   output logic                    wd_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    rd_last,
   input  logic                    rd_ready,
   output logic                    done,
   output logic [2:0]              done_resp,
   output logic                    done_err,
   output logic [ID_BITS-1:0]      awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [LEN_BITS-1:0]     awlen,
   output logic [SIZE_BITS-1:0]    awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [ID_BITS-1:0]      bid,
   input  logic [2:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ID_BITS-1:0]      arid,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [LEN_BITS-1:0]     arlen,
   output logic [SIZE_BITS-1:0]    arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [ID_BITS-1:0]      rid,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [2:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AW   = 3'd1;
   localparam logic [2:0] S_W    = 3'd2;
   localparam logic [2:0] S_B    = 3'd3;
   localparam logic [2:0] S_AR   = 3'd4;
   localparam logic [2:0] S_R    = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;

   localparam logic [SIZE_BITS-1:0] BEAT_SIZE =
      SIZE_BITS'($clog2(DATA_WIDTH / 8));

   logic [2:0]            state;
   logic [ID_BITS-1:0]    id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_BITS-1:0]   len_q;
   logic [LEN_BITS-1:0]   cnt;
   logic [2:0]            resp_q;
   logic                  err_q;

   logic in_idle, in_aw, in_w, in_b, in_ar, in_r, in_done;
   logic cnt_last, w_hs, r_hs;

   // Handshake outputs are forced low for the whole reset cycle.
   assign in_idle  = !rst_i && state == S_IDLE;
   assign in_aw    = !rst_i && state == S_AW;
   assign in_w     = !rst_i && state == S_W;
   assign in_b     = !rst_i && state == S_B;
   assign in_ar    = !rst_i && state == S_AR;
   assign in_r     = !rst_i && state == S_R;
   assign in_done  = !rst_i && state == S_DONE;

   assign cnt_last = cnt == len_q;
   assign w_hs     = in_w && wd_valid && wready;
   assign r_hs     = in_r && rvalid && rd_ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= S_IDLE;
         cnt    <= '0;
         resp_q <= '0;
         err_q  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (req_valid) begin
               id_q   <= req_id;
               addr_q <= req_addr;
               len_q  <= req_len;
               cnt    <= '0;
               resp_q <= '0;
               err_q  <= 1'b0;
               state  <= req_we ? S_AW : S_AR;
            end
            S_AW: if (awready) state <= S_W;
            S_W: if (w_hs) begin
               cnt <= cnt + 1'b1;
               if (cnt_last) state <= S_B;
            end
            S_B: if (bvalid) begin
               resp_q <= bresp;
               if (bid != id_q) err_q <= 1'b1;
               state <= S_DONE;
            end
            S_AR: if (arready) state <= S_R;
            S_R: if (r_hs) begin
               cnt <= cnt + 1'b1;
               if (rlast != cnt_last || rid != id_q) err_q <= 1'b1;
               if (resp_q == 3'b000) resp_q <= rresp;
               // A misplaced rlast or a missing one both end the burst here.
               if (rlast || cnt_last) state <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = in_idle;

   assign awid    = id_q;
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = BEAT_SIZE;
   assign awburst = 2'b01;
   assign awvalid = in_aw;

   assign wdata    = wd_data;
   assign wstrb    = '1;
   assign wlast    = in_w && cnt_last;
   assign wvalid   = in_w && wd_valid;
   assign wd_ready = in_w && wready;

   assign bready = in_b;

   assign arid    = id_q;
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = BEAT_SIZE;
   assign arburst = 2'b01;
   assign arvalid = in_ar;

   assign rready   = in_r && rd_ready;
   assign rd_valid = in_r && rvalid;
   assign rd_data  = rdata;
   assign rd_last  = in_r && rlast;

   assign done      = in_done;
   assign done_resp = resp_q;
   assign done_err  = in_done && err_q;

endmodule

// File: tb/tb_axi_master_port.sv
// Directed bench for axi_master_port: the bench plays the AXI slave and the
// request/stream client, one transaction record at a time.
module tb_axi_master_port;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid, req_ready, req_we;
   logic [3:0]  req_id;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic [31:0] wd_data;
   logic        wd_valid, wd_ready;
   logic [31:0] rd_data;
   logic        rd_valid, rd_last, rd_ready;
   logic        done, done_err;
   logic [2:0]  done_resp;
   logic [3:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize, bresp, rresp;
   logic [1:0]  awburst, arburst;
   logic        awvalid, awready, arvalid, arready;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic        bvalid, bready;
   logic        rlast, rvalid, rready;

   always #5 clk = ~clk;

   axi_master_port dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
      .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .rd_ready(rd_ready),
      .done(done), .done_resp(done_resp), .done_err(done_err),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   typedef struct {
      logic        we;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      int          aw_wait;
      logic        stall;
      int          resp_beat;
      logic [2:0]  resp;
      int          last_beat;
      logic        id_bad;
      logic [2:0]  exp_resp;
      logic        exp_err;
   } vec_t;

   vec_t tv[10];
   int checks;
   int errors;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      int lb, nb;
      logic [31:0] exp_d;
      lb = (v.last_beat < 0) ? int'(v.len) : v.last_beat;
      nb = (lb < int'(v.len)) ? lb : int'(v.len);
      req_valid = 1'b1;
      req_we    = v.we;
      req_id    = v.id;
      req_addr  = v.addr;
      req_len   = v.len;
      smp();
      chk("req_ready_idle", req_ready, 1);
      tick();
      req_valid = 1'b0;
      for (int k = 0; k <= v.aw_wait; k++) begin
         awready  = v.we && (k == v.aw_wait);
         arready  = !v.we && (k == v.aw_wait);
         wd_valid = 1'b1;
         wready   = 1'b1;
         rvalid   = 1'b1;
         rd_ready = 1'b1;
         smp();
         if (v.we) begin
            chk("awvalid", awvalid, 1);
            chk("awaddr", awaddr, v.addr);
            chk("awlen", awlen, v.len);
            chk("awid", awid, v.id);
            chk("awsize", awsize, 2);
            chk("awburst", awburst, 1);
            chk("arvalid_wr", arvalid, 0);
         end else begin
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, v.addr);
            chk("arlen", arlen, v.len);
            chk("arid", arid, v.id);
            chk("arsize", arsize, 2);
            chk("arburst", arburst, 1);
            chk("awvalid_rd", awvalid, 0);
         end
         chk("wvalid_pre", wvalid, 0);
         chk("wd_ready_pre", wd_ready, 0);
         chk("rd_valid_pre", rd_valid, 0);
         chk("rready_pre", rready, 0);
         chk("req_ready_busy", req_ready, 0);
         tick();
      end
      awready = 1'b0; arready = 1'b0;
      wd_valid = 1'b0; wready = 1'b0;
      rvalid = 1'b0; rd_ready = 1'b0;
      if (v.we) begin
         for (int b = 0; b <= int'(v.len); b++) begin
            exp_d    = 32'hDEADBEEF ^ b;
            wd_valid = 1'b1;
            wd_data  = exp_d;
            wready   = 1'b1;
            smp();
            chk("wvalid", wvalid, 1);
            chk("wdata", wdata, exp_d);
            chk("wstrb", wstrb, 4'hF);
            chk("wlast", wlast, b == int'(v.len));
            chk("wd_ready", wd_ready, 1);
            tick();
         end
         wd_valid = 1'b0; wready = 1'b0;
         bvalid = 1'b1;
         bid    = v.id ^ {3'b000, v.id_bad};
         bresp  = v.resp;
         smp();
         chk("bready", bready, 1);
         chk("done_early_b", done, 0);
         tick();
         bvalid = 1'b0;
      end else begin
         for (int b = 0; b <= nb; b++) begin
            exp_d  = (b + 1) * 32'h11;
            rvalid = 1'b1;
            rdata  = exp_d;
            rid    = v.id ^ {3'b000, v.id_bad};
            rlast  = (b == lb);
            if (b == v.resp_beat) rresp = v.resp;
            else if (b > v.resp_beat && v.resp != 3'b000) rresp = 3'b011;
            else rresp = 3'b000;
            if (v.stall) begin
               rd_ready = 1'b0;
               smp();
               chk("rd_valid_stall", rd_valid, 1);
               chk("rready_stall", rready, 0);
               chk("rd_data_stall", rd_data, exp_d);
               tick();
            end
            rd_ready = 1'b1;
            smp();
            chk("rd_valid", rd_valid, 1);
            chk("rready", rready, 1);
            chk("rd_data", rd_data, exp_d);
            chk("rd_last", rd_last, b == lb);
            chk("done_early_r", done, 0);
            tick();
         end
         rvalid = 1'b0; rd_ready = 1'b0; rlast = 1'b0; rresp = 3'b000;
      end
      smp();
      chk("done", done, 1);
      chk("done_resp", done_resp, v.exp_resp);
      chk("done_err", done_err, v.exp_err);
      chk("req_ready_done", req_ready, 0);
      tick();
      smp();
      chk("done_once", done, 0);
      chk("req_ready_after", req_ready, 1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      tv[0] = '{1'b1, 4'h3, 32'h100, 8'd0, 0, 1'b0, -1, 3'b000, -1, 1'b0, 3'b000, 1'b0};
      tv[1] = '{1'b0, 4'h5, 32'h200, 8'd3, 0, 1'b1, -1, 3'b000, -1, 1'b0, 3'b000, 1'b0};
      tv[2] = '{1'b1, 4'h1, 32'h300, 8'd1, 5, 1'b0, -1, 3'b000, -1, 1'b0, 3'b000, 1'b0};
      tv[3] = '{1'b1, 4'h2, 32'h400, 8'd0, 0, 1'b0, -1, 3'b010, -1, 1'b0, 3'b010, 1'b0};
      tv[4] = '{1'b0, 4'h4, 32'h500, 8'd3, 0, 1'b0, 1, 3'b010, -1, 1'b0, 3'b010, 1'b0};
      tv[5] = '{1'b0, 4'h7, 32'h700, 8'd3, 0, 1'b0, -1, 3'b000, 1, 1'b0, 3'b000, 1'b1};
      tv[6] = '{1'b0, 4'h8, 32'h800, 8'd1, 0, 1'b0, -1, 3'b000, 5, 1'b0, 3'b000, 1'b1};
      tv[7] = '{1'b0, 4'h9, 32'h900, 8'd1, 2, 1'b1, -1, 3'b000, -1, 1'b1, 3'b000, 1'b1};
      tv[8] = '{1'b1, 4'hA, 32'hA00, 8'd2, 0, 1'b0, -1, 3'b000, -1, 1'b1, 3'b000, 1'b1};
      tv[9] = '{1'b0, 4'hB, 32'hB00, 8'd0, 0, 1'b0, -1, 3'b000, -1, 1'b0, 3'b000, 1'b0};

      rst_i = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_id = '0; req_addr = '0; req_len = '0;
      wd_data = '0; wd_valid = 1'b0; rd_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bid = '0; bresp = '0; bvalid = 1'b0;
      rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      tick();
      tick();
      smp();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_done", done, 0);
      tick();
      rst_i = 1'b0;
      smp();
      chk("post_rst_req_ready", req_ready, 1);
      tick();

      for (int i = 0; i < 10; i++) run_vec(tv[i]);

      // Reset in the second beat of a 4-beat write.
      req_valid = 1'b1; req_we = 1'b1; req_id = 4'h6;
      req_addr = 32'h600; req_len = 8'd3;
      tick();
      req_valid = 1'b0;
      awready = 1'b1;
      tick();
      awready = 1'b0;
      wd_valid = 1'b1; wready = 1'b1; wd_data = 32'h1;
      smp();
      chk("rst_seq_beat0", wvalid, 1);
      tick();
      wd_data = 32'h2;
      rst_i = 1'b1;
      smp();
      chk("rst_seq_wvalid", wvalid, 0);
      chk("rst_seq_wd_ready", wd_ready, 0);
      chk("rst_seq_req_ready", req_ready, 0);
      tick();
      rst_i = 1'b0;
      wd_valid = 1'b0; wready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         smp();
         chk("rst_seq_idle", req_ready, 1);
         chk("rst_seq_nodone", done, 0);
         chk("rst_seq_awvalid", awvalid, 0);
         chk("rst_seq_wvalid2", wvalid, 0);
         tick();
      end
      run_vec(tv[1]);
      run_vec(tv[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
